count_enable_gen: RTL

Upstream stage of the N-bit up/down counter. Produces the single-cycle `en` pulse that advances the counter. Pulses come from two sources:
- a raw, asynchronous push-button input, after synchronization and debounce;
- a free-running prescaler tick, when auto mode is selected.

---
 rtl/count_enable_gen_if.sv | 13 +
 rtl/count_enable_gen.sv | 90 +++++++++
 2 files changed

// File: rtl/count_enable_gen_if.sv
// Button/auto-tick control bundle between the enable generator and whoever drives it.
interface count_enable_gen_if;
  logic btn_in;
  logic auto;
  logic clr;
  logic en;
  logic btn_level;
  logic busy;
  logic coll;

  modport master (output btn_in, auto, clr, input en, btn_level, busy, coll);
  modport slave  (input btn_in, auto, clr, output en, btn_level, busy, coll);
endinterface

// File: rtl/count_enable_gen.sv
// Count-enable source: debounced button presses OR'd with a free-running prescaler tick.
module count_enable_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int DIV        = 8
) (
  input  logic              clk,
  input  logic              rstn,
  count_enable_gen_if.slave bus
);
  localparam int DW = $clog2(DEB_CYCLES < 2 ? 2 : DEB_CYCLES);
  localparam int VW = $clog2(DIV < 2 ? 2 : DIV);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [VW-1:0] DIV_LAST = VW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  state_t          state, state_n;
  logic [1:0]      sync;
  logic            btn_s;
  logic [DW-1:0]   deb_cnt, deb_cnt_n;
  logic [VW-1:0]   div_cnt, div_cnt_n;
  logic            press, tick;
  logic            en_q, lvl_q, busy_q, coll_q;

  assign btn_s = sync[1];

  always_comb begin
    state_n   = state;
    deb_cnt_n = deb_cnt;
    press     = 1'b0;
    case (state)
      IDLE:
        if (btn_s) begin
          state_n   = PRESS_CHK;
          deb_cnt_n = '0;
        end
      PRESS_CHK:
        if (!btn_s) state_n = IDLE;
        else if (deb_cnt == DEB_LAST) begin
          state_n = PRESSED;
          press   = 1'b1;
        end else deb_cnt_n = deb_cnt + DW'(1);
      PRESSED:
        if (!btn_s) begin
          state_n   = RELEASE_CHK;
          deb_cnt_n = '0;
        end
      RELEASE_CHK:
        if (btn_s) state_n = PRESSED;
        else if (deb_cnt == DEB_LAST) state_n = IDLE;
        else deb_cnt_n = deb_cnt + DW'(1);
      default: state_n = IDLE;
    endcase
  end

  // Dropping auto parks the prescaler at 0 so re-enable always waits a full period.
  always_comb begin
    tick = bus.auto && (div_cnt == DIV_LAST);
    if (!bus.auto || tick) div_cnt_n = '0;
    else                   div_cnt_n = div_cnt + VW'(1);
  end

  // Level/busy decode the next state so they line up with the en pulse edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync    <= '0;
      state   <= IDLE;
      deb_cnt <= '0;
      div_cnt <= '0;
      en_q    <= 1'b0;
      lvl_q   <= 1'b0;
      busy_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      sync    <= {sync[0], bus.btn_in};
      state   <= state_n;
      deb_cnt <= deb_cnt_n;
      div_cnt <= div_cnt_n;
      en_q    <= press | tick;
      lvl_q   <= (state_n == PRESSED) || (state_n == RELEASE_CHK);
      busy_q  <= (state_n == PRESS_CHK) || (state_n == RELEASE_CHK);
      coll_q  <= (press & tick) | (coll_q & ~bus.clr);
    end
  end

  assign bus.en        = en_q;
  assign bus.btn_level = lvl_q;
  assign bus.busy      = busy_q;
  assign bus.coll      = coll_q;
endmodule
